// File: rtl/mem_bus_requester.sv
// rtl/mem_bus_requester.sv - two-client line load/store initiator for the unified memory bus
//
// Arbitrates 64-bit line requests from client 0 (D-cache, priority) and
// client 1 (I-cache, starvation-protected), drives the proc2mem bus
// combinationally, tracks in-flight loads by memory tag and routes returning
// load data back to the owning client.
//
// Ports:
//   clock, reset          system clock, synchronous active-high reset
//   req_valid/is_store    per-client request valid and store select
//   req_addr/req_data     per-client byte address (packed 2 x XLEN) and store data (2 x 64)
//   req_ready             per-client acceptance, combinational
//   rsp_valid/client/     registered load return: owner, line address, data
//     addr/data
//   store_ack             per-client one-cycle pulse after a store is accepted
//   outstanding_cnt       number of loads in flight
//   stray_tag             sticky: a returned tag matched no in-flight load
//   proc2mem_*            bus command (NONE/LOAD/STORE), line address, store data
//   mem2proc_response     accept tag for the current command, 0 = rejected
//   mem2proc_tag/data     returning load tag (0 = none) and its data

module mem_bus_requester #(
    parameter int OUTSTANDING  = 4,
    parameter int STARVE_LIMIT = 4,
    parameter int XLEN         = 32
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [1:0]                  req_valid,
    input  logic [1:0]                  req_is_store,
    input  logic [2*XLEN-1:0]           req_addr,
    input  logic [127:0]                req_data,
    output logic [1:0]                  req_ready,
    output logic                        rsp_valid,
    output logic                        rsp_client,
    output logic [XLEN-1:0]             rsp_addr,
    output logic [63:0]                 rsp_data,
    output logic [1:0]                  store_ack,
    output logic [$clog2(OUTSTANDING):0] outstanding_cnt,
    output logic                        stray_tag,
    output logic [1:0]                  proc2mem_command,
    output logic [XLEN-1:0]             proc2mem_addr,
    output logic [63:0]                 proc2mem_data,
    input  logic [3:0]                  mem2proc_response,
    input  logic [63:0]                 mem2proc_data,
    input  logic [3:0]                  mem2proc_tag
);

    localparam int CW = $clog2(OUTSTANDING) + 1;
    localparam int IW = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    localparam logic [1:0] BUS_NONE  = 2'd0;
    localparam logic [1:0] BUS_LOAD  = 2'd1;
    localparam logic [1:0] BUS_STORE = 2'd2;

    // In-flight load table
    logic [OUTSTANDING-1:0] ent_valid_q, ent_valid_d;
    logic [3:0]             ent_tag_q    [OUTSTANDING];
    logic [3:0]             ent_tag_d    [OUTSTANDING];
    logic                   ent_client_q [OUTSTANDING];
    logic                   ent_client_d [OUTSTANDING];
    logic [XLEN-1:3]        ent_line_q   [OUTSTANDING];
    logic [XLEN-1:3]        ent_line_d   [OUTSTANDING];

    logic [CW-1:0]   cnt_q, cnt_d;
    logic [SW-1:0]   starve_q, starve_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic            rsp_client_q, rsp_client_d;
    logic [XLEN-1:3] rsp_line_q, rsp_line_d;
    logic [63:0]     rsp_data_q, rsp_data_d;
    logic [1:0]      store_ack_q, store_ack_d;
    logic            stray_q, stray_d;

    // Arbitration and bus drive
    logic [1:0]      elig;
    logic            win_valid;
    logic            win_sel;
    logic            win_store;
    logic [XLEN-1:3] win_line;
    logic [63:0]     win_data;
    logic            accept;
    logic            load_acc;

    // The low three address bits never reach the bus.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{req_addr[XLEN+2:XLEN], req_addr[2:0]};

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            elig[i] = req_valid[i] & (req_is_store[i] | (cnt_q < CW'(OUTSTANDING)));
        end
        // Client 1 wins when client 0 is not eligible, or once it has been
        // passed over STARVE_LIMIT times in a row.
        win_sel   = elig[1] & ((starve_q == SW'(STARVE_LIMIT)) | ~elig[0]);
        win_valid = ~reset & (|elig);
        win_store = win_sel ? req_is_store[1] : req_is_store[0];
        win_line  = win_sel ? req_addr[2*XLEN-1:XLEN+3] : req_addr[XLEN-1:3];
        win_data  = win_sel ? req_data[127:64] : req_data[63:0];
        accept    = win_valid & (mem2proc_response != 4'd0);
        load_acc  = accept & ~win_store;

        proc2mem_command = BUS_NONE;
        proc2mem_addr    = '0;
        proc2mem_data    = '0;
        req_ready        = 2'b00;
        if (win_valid) begin
            proc2mem_command = win_store ? BUS_STORE : BUS_LOAD;
            proc2mem_addr    = {win_line, 3'b000};
            proc2mem_data    = win_store ? win_data : 64'd0;
        end
        if (accept) begin
            req_ready = win_sel ? 2'b10 : 2'b01;
        end
    end

    // Tag match and free-slot search, both against pre-update table state,
    // so a slot freed this cycle is never the one reallocated this cycle.
    logic          hit;
    logic [IW-1:0] hit_idx;
    logic [IW-1:0] alloc_idx;
    logic          alloc_found;

    always_comb begin
        hit         = 1'b0;
        hit_idx     = '0;
        alloc_found = 1'b0;
        alloc_idx   = '0;
        for (int i = 0; i < OUTSTANDING; i++) begin
            if (!hit && ent_valid_q[i] && mem2proc_tag != 4'd0 && ent_tag_q[i] == mem2proc_tag) begin
                hit     = 1'b1;
                hit_idx = IW'(i);
            end
            if (!alloc_found && !ent_valid_q[i]) begin
                alloc_found = 1'b1;
                alloc_idx   = IW'(i);
            end
        end
    end

    always_comb begin
        ent_valid_d  = ent_valid_q;
        ent_tag_d    = ent_tag_q;
        ent_client_d = ent_client_q;
        ent_line_d   = ent_line_q;
        rsp_valid_d  = hit;
        rsp_client_d = rsp_client_q;
        rsp_line_d   = rsp_line_q;
        rsp_data_d   = rsp_data_q;
        stray_d      = stray_q | ((mem2proc_tag != 4'd0) & ~hit);
        store_ack_d  = 2'b00;
        starve_d     = starve_q;

        if (hit) begin
            ent_valid_d[hit_idx] = 1'b0;
            rsp_client_d         = ent_client_q[hit_idx];
            rsp_line_d           = ent_line_q[hit_idx];
            rsp_data_d           = mem2proc_data;
        end

        // Load eligibility guarantees a free slot exists when load_acc is set.
        if (load_acc && alloc_found) begin
            ent_valid_d[alloc_idx]  = 1'b1;
            ent_tag_d[alloc_idx]    = mem2proc_response;
            ent_client_d[alloc_idx] = win_sel;
            ent_line_d[alloc_idx]   = win_line;
        end

        if (accept && win_store) begin
            store_ack_d = win_sel ? 2'b10 : 2'b01;
        end

        cnt_d = cnt_q + CW'(load_acc) - CW'(hit);

        // A rejected command leaves the starvation counter where it was.
        if (!win_valid) begin
            starve_d = '0;
        end else if (accept) begin
            if (win_sel || !elig[1]) begin
                starve_d = '0;
            end else begin
                starve_d = starve_q + SW'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ent_valid_q  <= '0;
            for (int i = 0; i < OUTSTANDING; i++) begin
                ent_tag_q[i]    <= '0;
                ent_client_q[i] <= 1'b0;
                ent_line_q[i]   <= '0;
            end
            cnt_q        <= '0;
            starve_q     <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_client_q <= 1'b0;
            rsp_line_q   <= '0;
            rsp_data_q   <= '0;
            store_ack_q  <= 2'b00;
            stray_q      <= 1'b0;
        end else begin
            ent_valid_q  <= ent_valid_d;
            ent_tag_q    <= ent_tag_d;
            ent_client_q <= ent_client_d;
            ent_line_q   <= ent_line_d;
            cnt_q        <= cnt_d;
            starve_q     <= starve_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_client_q <= rsp_client_d;
            rsp_line_q   <= rsp_line_d;
            rsp_data_q   <= rsp_data_d;
            store_ack_q  <= store_ack_d;
            stray_q      <= stray_d;
        end
    end

    assign rsp_valid       = rsp_valid_q;
    assign rsp_client      = rsp_client_q;
    assign rsp_addr        = {rsp_line_q, 3'b000};
    assign rsp_data        = rsp_data_q;
    assign store_ack       = store_ack_q;
    assign outstanding_cnt = cnt_q;
    assign stray_tag       = stray_q;

endmodule

// File: tb/tb_mem_bus_requester.sv
// tb/tb_mem_bus_requester.sv - self-checking bench for mem_bus_requester

module tb_mem_bus_requester;

    localparam int OUTSTANDING  = 4;
    localparam int STARVE_LIMIT = 4;
    localparam int XLEN         = 32;

    logic         clock;
    logic         reset;
    logic [1:0]   req_valid, req_is_store, req_ready;
    logic [63:0]  req_addr;
    logic [127:0] req_data;
    logic         rsp_valid, rsp_client;
    logic [31:0]  rsp_addr;
    logic [63:0]  rsp_data;
    logic [1:0]   store_ack;
    logic [2:0]   outstanding_cnt;
    logic         stray_tag;
    logic [1:0]   proc2mem_command;
    logic [31:0]  proc2mem_addr;
    logic [63:0]  proc2mem_data;
    logic [3:0]   mem2proc_response;
    logic [63:0]  mem2proc_data;
    logic [3:0]   mem2proc_tag;

    mem_bus_requester #(.OUTSTANDING(OUTSTANDING), .STARVE_LIMIT(STARVE_LIMIT), .XLEN(XLEN)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_is_store(req_is_store),
        .req_addr(req_addr), .req_data(req_data), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_client(rsp_client), .rsp_addr(rsp_addr), .rsp_data(rsp_data),
        .store_ack(store_ack), .outstanding_cnt(outstanding_cnt), .stray_tag(stray_tag),
        .proc2mem_command(proc2mem_command), .proc2mem_addr(proc2mem_addr), .proc2mem_data(proc2mem_data),
        .mem2proc_response(mem2proc_response), .mem2proc_data(mem2proc_data), .mem2proc_tag(mem2proc_tag)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: in-flight loads as an unordered list keyed by tag.
    typedef struct {
        logic [3:0]  tag;
        logic        client;
        logic [31:0] addr;
    } ent_t;

    ent_t        m_q[$];
    int          m_starve;
    logic        m_rv, m_rc, m_stray;
    logic [31:0] m_ra;
    logic [63:0] m_rd;
    logic [1:0]  m_ack;

    function automatic void model_clear();
        m_q.delete();
        m_starve = 0;
        m_rv = 0; m_rc = 0; m_ra = 0; m_rd = 0;
        m_ack = 0; m_stray = 0;
    endfunction

    function automatic bit tag_in_flight(input logic [3:0] t);
        foreach (m_q[i]) if (m_q[i].tag == t) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_step();
        int          ocnt, win, hit;
        logic [1:0]  elig, e_rdy, e_cmd;
        logic [31:0] e_addr;
        logic [63:0] e_data;
        bit          acc, st;
        ocnt = m_q.size();
        for (int i = 0; i < 2; i++) elig[i] = req_valid[i] & (req_is_store[i] | (ocnt < OUTSTANDING));
        win = -1;
        if (!reset) begin
            if (m_starve == STARVE_LIMIT && elig[1]) win = 1;
            else if (elig[0]) win = 0;
            else if (elig[1]) win = 1;
        end
        acc = (win >= 0) && (mem2proc_response != 0);
        st  = (win >= 0) && req_is_store[win];
        e_cmd = 0; e_addr = 0; e_data = 0; e_rdy = 0;
        if (win >= 0) begin
            e_cmd  = st ? 2'd2 : 2'd1;
            e_addr = (win == 1 ? req_addr[63:32] : req_addr[31:0]) & ~32'h7;
            if (st) e_data = (win == 1) ? req_data[127:64] : req_data[63:0];
        end
        if (acc) e_rdy[win] = 1'b1;
        chk("m_cmd", proc2mem_command, e_cmd);
        chk("m_addr", proc2mem_addr, e_addr);
        chk("m_data", proc2mem_data, e_data);
        chk("m_ready", req_ready, e_rdy);
        chk("m_rsp_valid", rsp_valid, m_rv);
        if (m_rv) begin
            chk("m_rsp_client", rsp_client, m_rc);
            chk("m_rsp_addr", rsp_addr, m_ra);
            chk("m_rsp_data", rsp_data, m_rd);
        end
        chk("m_store_ack", store_ack, m_ack);
        chk("m_count", outstanding_cnt, ocnt);
        chk("m_stray", stray_tag, m_stray);
        if (reset) begin
            model_clear();
            return;
        end
        m_rv = 0;
        if (mem2proc_tag != 0) begin
            hit = -1;
            foreach (m_q[i]) if (hit < 0 && m_q[i].tag == mem2proc_tag) hit = i;
            if (hit >= 0) begin
                m_rv = 1; m_rc = m_q[hit].client; m_ra = m_q[hit].addr; m_rd = mem2proc_data;
                m_q.delete(hit);
            end else begin
                m_stray = 1;
            end
        end
        if (acc && !st) m_q.push_back('{mem2proc_response, logic'(win), e_addr});
        m_ack = 0;
        if (acc && st) m_ack[win] = 1'b1;
        if (win < 0) m_starve = 0;
        else if (acc) m_starve = (win == 1 || !elig[1]) ? 0 : m_starve + 1;
    endtask

    task automatic set_in(input logic [1:0] rv, input logic [1:0] st, input logic [31:0] a0,
                          input logic [31:0] a1, input logic [63:0] d1, input logic [3:0] resp,
                          input logic [3:0] tag, input logic [63:0] rdat);
        req_valid = rv; req_is_store = st;
        req_addr = {a1, a0}; req_data = {d1, 64'd0};
        mem2proc_response = resp; mem2proc_tag = tag; mem2proc_data = rdat;
    endtask

    task automatic settle();
        #1;
        model_step();
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input logic [3:0] tag, input logic [63:0] rdat);
        set_in(0, 0, 0, 0, 0, 0, tag, rdat);
        settle();
        tick();
    endtask

    task automatic do_reset();
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        model_clear();
    endtask

    typedef struct {
        logic [1:0]  rv, st;
        logic [31:0] a0, a1;
        logic [63:0] d1;
        logic [3:0]  resp, tag;
        logic [63:0] rdat;
        logic [1:0]  e_cmd;
        logic [31:0] e_addr;
        logic [63:0] e_data;
        logic [1:0]  e_rdy;
        logic        e_rv, e_rc;
        logic [31:0] e_raddr;
        logic [63:0] e_rdata;
        logic [1:0]  e_ack;
        logic [2:0]  e_cnt;
    } vec_t;

    vec_t vt[15];
    int   grant_seq[10];

    initial begin
        // rv st a0 a1 d1 resp tag rdat | cmd addr data rdy rv rc raddr rdata ack cnt
        vt[0]  = '{0, 0, 0, 0, 0, 0, 0, 0,                     0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        vt[1]  = '{1, 0, 'h10F, 0, 0, 3, 0, 0,                 1, 'h108, 0, 1, 0, 0, 0, 0, 0, 0};
        vt[2]  = '{0, 0, 0, 0, 0, 0, 0, 0,                     0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
        vt[3]  = '{0, 0, 0, 0, 0, 0, 3, 64'hDEADBEEF01234567,  0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
        vt[4]  = '{0, 0, 0, 0, 0, 0, 0, 0,                     0, 0, 0, 0, 1, 0, 'h108, 64'hDEADBEEF01234567, 0, 0};
        vt[5]  = '{2, 2, 0, 'h20, 'h55, 7, 0, 0,               2, 'h20, 'h55, 2, 0, 0, 0, 0, 0, 0};
        vt[6]  = '{0, 0, 0, 0, 0, 0, 0, 0,                     0, 0, 0, 0, 0, 0, 0, 0, 2, 0};
        vt[7]  = '{0, 0, 0, 0, 0, 0, 0, 0,                     0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        vt[8]  = '{1, 0, 'h40, 0, 0, 0, 0, 0,                  1, 'h40, 0, 0, 0, 0, 0, 0, 0, 0};
        vt[9]  = '{1, 0, 'h40, 0, 0, 0, 0, 0,                  1, 'h40, 0, 0, 0, 0, 0, 0, 0, 0};
        vt[10] = '{1, 0, 'h40, 0, 0, 0, 0, 0,                  1, 'h40, 0, 0, 0, 0, 0, 0, 0, 0};
        vt[11] = '{1, 0, 'h40, 0, 0, 1, 0, 0,                  1, 'h40, 0, 1, 0, 0, 0, 0, 0, 0};
        vt[12] = '{0, 0, 0, 0, 0, 0, 0, 0,                     0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
        vt[13] = '{0, 0, 0, 0, 0, 0, 1, 'h1111,                0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
        vt[14] = '{0, 0, 0, 0, 0, 0, 0, 0,                     0, 0, 0, 0, 1, 0, 'h40, 'h1111, 0, 0};
        grant_seq = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};

        reset = 1'b1;
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        tick();
        reset = 1'b0;
        model_clear();

        // Directed vectors: reset state, single load, store, rejection
        foreach (vt[i]) begin
            set_in(vt[i].rv, vt[i].st, vt[i].a0, vt[i].a1, vt[i].d1, vt[i].resp, vt[i].tag, vt[i].rdat);
            settle();
            chk($sformatf("v%0d_cmd", i), proc2mem_command, vt[i].e_cmd);
            chk($sformatf("v%0d_addr", i), proc2mem_addr, vt[i].e_addr);
            chk($sformatf("v%0d_data", i), proc2mem_data, vt[i].e_data);
            chk($sformatf("v%0d_ready", i), req_ready, vt[i].e_rdy);
            chk($sformatf("v%0d_rsp_valid", i), rsp_valid, vt[i].e_rv);
            if (vt[i].e_rv) begin
                chk($sformatf("v%0d_rsp_client", i), rsp_client, vt[i].e_rc);
                chk($sformatf("v%0d_rsp_addr", i), rsp_addr, vt[i].e_raddr);
                chk($sformatf("v%0d_rsp_data", i), rsp_data, vt[i].e_rdata);
            end
            chk($sformatf("v%0d_store_ack", i), store_ack, vt[i].e_ack);
            chk($sformatf("v%0d_count", i), outstanding_cnt, vt[i].e_cnt);
            tick();
        end

        // Starvation: both clients loading every cycle, previous tag returns
        for (int i = 0; i < 10; i++) begin
            set_in(3, 0, 'h1000, 'h2000, 0, 4'(i + 1), (i == 0) ? 4'd0 : 4'(i), 'h100 + i);
            settle();
            chk($sformatf("starve_grant%0d", i), req_ready, grant_seq[i] == 1 ? 2'b10 : 2'b01);
            tick();
        end
        idle(10, 'h77);

        // Full table: loads blocked, store passes, a return reopens a slot
        for (int k = 0; k < 4; k++) begin
            set_in(1, 0, 'h300 + 8 * k, 0, 0, 4'(k + 1), 0, 0);
            settle();
            tick();
        end
        set_in(3, 2, 'h400, 'h500, 'hAA, 6, 0, 0);
        settle();
        chk("full_store_cmd", proc2mem_command, 2);
        chk("full_store_ready", req_ready, 2'b10);
        chk("full_count", outstanding_cnt, 4);
        tick();
        set_in(1, 0, 'h400, 0, 0, 7, 2, 'h2222);
        settle();
        chk("full_load_blocked", proc2mem_command, 0);
        chk("full_load_ready", req_ready, 0);
        tick();
        set_in(1, 0, 'h400, 0, 0, 7, 0, 0);
        settle();
        chk("freed_load_cmd", proc2mem_command, 1);
        chk("freed_load_addr", proc2mem_addr, 'h400);
        chk("freed_load_ready", req_ready, 2'b01);
        chk("freed_count", outstanding_cnt, 3);
        chk("freed_rsp_addr", rsp_addr, 'h308);
        tick();
        idle(1, 'h1); idle(3, 'h3); idle(4, 'h4); idle(7, 'h7);

        // Same-cycle free and reuse of tag 5
        set_in(2, 0, 0, 'h600, 0, 5, 0, 0);
        settle();
        tick();
        set_in(1, 0, 'h700, 0, 0, 5, 5, 'hAAAA);
        settle();
        chk("reuse_ready", req_ready, 2'b01);
        tick();
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        settle();
        chk("reuse_old_client", rsp_client, 1);
        chk("reuse_old_addr", rsp_addr, 'h600);
        chk("reuse_old_data", rsp_data, 'hAAAA);
        chk("reuse_count", outstanding_cnt, 1);
        tick();
        idle(5, 'hBBBB);
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        settle();
        chk("reuse_new_valid", rsp_valid, 1);
        chk("reuse_new_client", rsp_client, 0);
        chk("reuse_new_addr", rsp_addr, 'h700);
        tick();

        // Randomised traffic against the model
        for (int c = 0; c < 3000; c++) begin
            logic [3:0] resp, tag;
            int r;
            req_valid    = 2'($urandom);
            req_is_store = 2'($urandom);
            req_addr     = {$urandom, $urandom};
            req_data     = {$urandom, $urandom, $urandom, $urandom};
            resp = 0;
            if ($urandom_range(3) != 0) begin
                do resp = 4'($urandom_range(15, 1)); while (tag_in_flight(resp));
            end
            tag = 0;
            r = $urandom_range(9);
            if (r < 4 && m_q.size() > 0) tag = m_q[$urandom_range(m_q.size() - 1)].tag;
            else if (r == 4 && m_q.size() < 15) begin
                do tag = 4'($urandom_range(15, 1)); while (tag_in_flight(tag));
            end
            mem2proc_response = resp;
            mem2proc_tag      = tag;
            mem2proc_data     = {$urandom, $urandom};
            settle();
            tick();
        end

        // Reset with two loads in flight; their late tags are strays
        do_reset();
        set_in(1, 0, 'h800, 0, 0, 9, 0, 0);
        settle();
        tick();
        set_in(2, 0, 0, 'h900, 0, 10, 0, 0);
        settle();
        tick();
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b1;
        settle();
        tick();
        reset = 1'b0;
        idle(9, 'h9999);
        idle(10, 'hAAAA);
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        settle();
        chk("rst_stray", stray_tag, 1);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_count", outstanding_cnt, 0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
